// File: rtl/bytecode_memory.sv
// bytecode_memory: byte-addressed program store that answers decoder fetches.
// A fetch returns four consecutive bytes, big-endian, LATENCY+1 cycles after
// the request is accepted. A byte-wide load port writes the store at any time.
// Optional macro BYTECODE_MEM_RANGE_CHECK_EN adds a mem_error output. With it,
// fetches running past the end of the store and loads beyond the store are
// rejected. Without it, every address wraps modulo DEPTH.
// The byte-width parameter is named byte_size because "byte" is a reserved word.
module bytecode_memory #(
  parameter int byte_size    = 8,
  parameter int width_out    = 4 * byte_size,
  parameter int address_size = 16,
  parameter int DEPTH        = 256,
  parameter int LATENCY      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_for_memory,
  input  logic [address_size-1:0] address_for_memory,
  output logic [width_out-1:0]    instruction_data,
  output logic                    ready,
  output logic                    busy,
`ifdef BYTECODE_MEM_RANGE_CHECK_EN
  output logic                    mem_error,
`endif
  input  logic                    load_en,
  input  logic [address_size-1:0] load_addr,
  input  logic [byte_size-1:0]    load_byte
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CW-1:0]           count;
  logic [address_size-1:0] addr_q;
  logic [byte_size-1:0]    mem [DEPTH];

  logic                    accept;
  logic                    capture;
  logic                    load_ok;
  logic                    fetch_err;
  logic [IW-1:0]           idx0;
  logic [IW-1:0]           idx1;
  logic [IW-1:0]           idx2;
  logic [IW-1:0]           idx3;
  logic [width_out-1:0]    word;

  assign accept  = start_for_memory && (state == IDLE || state == RESP);
  assign capture = (state == WAIT) && (count == '0);

  // Each of the four byte indices wraps around the store on its own.
  assign idx0 = addr_q[IW-1:0];
  assign idx1 = idx0 + IW'(1);
  assign idx2 = idx0 + IW'(2);
  assign idx3 = idx0 + IW'(3);
  assign word = {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};

`ifdef BYTECODE_MEM_RANGE_CHECK_EN
  // Compare in one extra bit so that an address near the top cannot overflow.
  assign fetch_err = ({1'b0, addr_q} + (address_size+1)'(3)) >= (address_size+1)'(DEPTH);
  assign load_ok   = {1'b0, load_addr} < (address_size+1)'(DEPTH);
`else
  logic unused_bits;
  assign fetch_err   = 1'b0;
  assign load_ok     = 1'b1;
  assign unused_bits = ^{addr_q[address_size-1:IW], load_addr[address_size-1:IW]};
`endif

  // State register; reset abandons any fetch in progress.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: requests arriving during WAIT are dropped, not queued.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_for_memory) state_next = WAIT;
      WAIT:    if (count == '0)      state_next = RESP;
      RESP:    state_next = start_for_memory ? WAIT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: ready marks the single response cycle, busy marks the wait.
  always_comb begin
    ready = (state == RESP);
    busy  = (state == WAIT);
  end

  // Fetch datapath: latch the request, count the wait and capture the word.
  always_ff @(posedge clk) begin
    if (reset) begin
      count            <= '0;
      addr_q           <= '0;
      instruction_data <= '0;
`ifdef BYTECODE_MEM_RANGE_CHECK_EN
      mem_error        <= 1'b0;
`endif
    end else begin
`ifdef BYTECODE_MEM_RANGE_CHECK_EN
      mem_error <= capture && fetch_err;
`endif
      if (accept) begin
        addr_q <= address_for_memory;
        count  <= CW'(LATENCY - 1);
      end else if (state == WAIT && count != '0) begin
        count <= count - CW'(1);
      end
      if (capture) instruction_data <= fetch_err ? '0 : word;
    end
  end

  // Load port; memory reads at the same edge still see the old byte.
  always_ff @(posedge clk) begin
    if (!reset && load_en && load_ok) mem[load_addr[IW-1:0]] <= load_byte;
  end

endmodule

// File: tb/tb_bytecode_memory.sv
// tb_bytecode_memory: directed, self-checking bench for bytecode_memory.
// Define BYTECODE_MEM_RANGE_CHECK_EN for both files to exercise mem_error.
module tb_bytecode_memory;

  logic        clk;
  logic        reset;
  logic        start_for_memory;
  logic [15:0] address_for_memory;
  logic [31:0] instruction_data;
  logic        ready;
  logic        busy;
  logic        load_en;
  logic [15:0] load_addr;
  logic [7:0]  load_byte;
`ifdef BYTECODE_MEM_RANGE_CHECK_EN
  logic        mem_error;
`endif

  int total = 0;
  int bad   = 0;

  bytecode_memory dut (
    .clk                (clk),
    .reset              (reset),
    .start_for_memory   (start_for_memory),
    .address_for_memory (address_for_memory),
    .instruction_data   (instruction_data),
    .ready              (ready),
    .busy               (busy),
`ifdef BYTECODE_MEM_RANGE_CHECK_EN
    .mem_error          (mem_error),
`endif
    .load_en            (load_en),
    .load_addr          (load_addr),
    .load_byte          (load_byte)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count a comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then move 1 ns past the next rising edge.
  task automatic applyStimulus(input logic s, input logic [15:0] a,
                               input logic le, input logic [15:0] la, input logic [7:0] lb);
    start_for_memory   = s;
    address_for_memory = a;
    load_en            = le;
    load_addr          = la;
    load_byte          = lb;
    @(posedge clk);
    #1;
  endtask

  task automatic loadByte(input logic [15:0] a, input logic [7:0] d);
    applyStimulus(1'b0, 16'h0, 1'b1, a, d);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 8'h0);
  endtask

  // Single fetch, with the timing checked cycle by cycle.
  // Request cycle T; busy in T+1..T+2; ready only in T+3; data held in T+4.
  task automatic fetchCheck(input string tag, input logic [15:0] a,
                            input logic [31:0] exp, input logic err);
    applyStimulus(1'b1, a, 1'b0, 16'h0, 8'h0);
    checkOutput({tag, " busy T+1"},  32'(busy),  32'd1);
    checkOutput({tag, " ready T+1"}, 32'(ready), 32'd0);
    idleCycle();
    checkOutput({tag, " busy T+2"},  32'(busy),  32'd1);
    checkOutput({tag, " ready T+2"}, 32'(ready), 32'd0);
    idleCycle();
    checkOutput({tag, " ready T+3"}, 32'(ready), 32'd1);
    checkOutput({tag, " busy T+3"},  32'(busy),  32'd0);
    checkOutput({tag, " data T+3"},  instruction_data, exp);
`ifdef BYTECODE_MEM_RANGE_CHECK_EN
    checkOutput({tag, " err T+3"}, 32'(mem_error), 32'(err));
`else
    if (err) $display("[TB] note: %s expects an error but range check is off", tag);
`endif
    idleCycle();
    checkOutput({tag, " ready T+4"}, 32'(ready), 32'd0);
    checkOutput({tag, " hold T+4"},  instruction_data, exp);
`ifdef BYTECODE_MEM_RANGE_CHECK_EN
    checkOutput({tag, " err T+4"}, 32'(mem_error), 32'd0);
`endif
  endtask

  initial begin
    reset = 1'b1;
    start_for_memory = 1'b0;
    address_for_memory = 16'h0;
    load_en = 1'b0;
    load_addr = 16'h0;
    load_byte = 8'h0;
    idleCycle();
    idleCycle();
    checkOutput("reset ready", 32'(ready), 32'd0);
    checkOutput("reset busy",  32'(busy),  32'd0);
    checkOutput("reset data",  instruction_data, 32'h0);
`ifdef BYTECODE_MEM_RANGE_CHECK_EN
    checkOutput("reset err", 32'(mem_error), 32'd0);
`endif
    reset = 1'b0;
    idleCycle();

    // Program image.
    loadByte(16'h0000, 8'h03);
    loadByte(16'h0001, 8'h04);
    loadByte(16'h0002, 8'h6f);
    loadByte(16'h0003, 8'h91);
    loadByte(16'h00FE, 8'h50);
    loadByte(16'h00FF, 8'h91);
    loadByte(16'h00FC, 8'h11);
    loadByte(16'h00FD, 8'h22);

    fetchCheck("basic", 16'h0000, 32'h03046f91, 1'b0);

`ifdef BYTECODE_MEM_RANGE_CHECK_EN
    fetchCheck("range FE", 16'h00FE, 32'h0, 1'b1);
    fetchCheck("range FC", 16'h00FC, 32'h11225091, 1'b0);
    loadByte(16'h0100, 8'hEE);
    fetchCheck("drop load", 16'h0000, 32'h03046f91, 1'b0);
`else
    fetchCheck("wrap FE",  16'h00FE, 32'h50910304, 1'b0);
    fetchCheck("alias 1FE", 16'h01FE, 32'h50910304, 1'b0);
    fetchCheck("top FC",   16'h00FC, 32'h11225091, 1'b0);
`endif

    // Continuous start: a response every third cycle.
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1'b1, 16'h0000, 1'b0, 16'h0, 8'h0);
      checkOutput($sformatf("b2b ready c%0d", i), 32'(ready), 32'((i % 3) == 0));
      if ((i % 3) == 0) checkOutput($sformatf("b2b data c%0d", i), instruction_data, 32'h03046f91);
    end
    idleCycle();
    checkOutput("b2b stop", 32'(ready), 32'd0);

    // A request during WAIT is ignored.
    applyStimulus(1'b1, 16'h0000, 1'b0, 16'h0, 8'h0);
    applyStimulus(1'b1, 16'h00FC, 1'b0, 16'h0, 8'h0);
    checkOutput("ign busy", 32'(busy), 32'd1);
    idleCycle();
    checkOutput("ign ready", 32'(ready), 32'd1);
    checkOutput("ign data",  instruction_data, 32'h03046f91);
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkOutput($sformatf("ign no extra %0d", i), 32'(ready), 32'd0);
      checkOutput($sformatf("ign idle %0d", i),     32'(busy),  32'd0);
    end

    // Reset during WAIT aborts the fetch and blocks a simultaneous load.
    applyStimulus(1'b1, 16'h0000, 1'b0, 16'h0, 8'h0);
    reset = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0002, 8'h00);
    checkOutput("rst busy",  32'(busy),  32'd0);
    checkOutput("rst ready", 32'(ready), 32'd0);
    checkOutput("rst data",  instruction_data, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkOutput($sformatf("rst no ready %0d", i), 32'(ready), 32'd0);
    end
    fetchCheck("after rst", 16'h0000, 32'h03046f91, 1'b0);

    // Load into a fetched byte at the capture edge: old byte returned.
    applyStimulus(1'b1, 16'h0000, 1'b0, 16'h0, 8'h0);
    idleCycle();
    applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0001, 8'hAA);
    checkOutput("coll ready", 32'(ready), 32'd1);
    checkOutput("coll data",  instruction_data, 32'h03046f91);
    idleCycle();
    fetchCheck("coll next", 16'h0000, 32'h03AA6f91, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no end expected end");
    $fatal(1, "[TB] timeout");
  end

endmodule
